// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: hands the command/address bus to init, refresh, write or read
// sequencers, with a periodic refresh request that outranks write and read.
module sdram_arbit #(
  parameter int         REF_PERIOD = 390,
  parameter logic [3:0] CMD_NOP    = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flag_init_end,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic [3:0]  ref_cmd,
  input  logic [12:0] ref_addr,
  input  logic        flag_ref_end,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_bank,
  input  logic        wr_end,
  input  logic        rd_end,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        ref_pend,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } arb_state_t;

  localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TW-1:0] TMAX = TW'(REF_PERIOD - 1);

  arb_state_t    st;
  logic [TW-1:0] ref_timer;
  logic          wrap;

  assign state = st;
  assign wrap  = flag_init_end && (ref_timer == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ref_timer <= '0;
    else if (!flag_init_end) ref_timer <= '0;
    else if (wrap)           ref_timer <= '0;
    else                     ref_timer <= ref_timer + 1'b1;
  end

  // Set beats clear: a wrap on the AREF-entry cycle leaves a fresh request pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             ref_pend <= 1'b0;
    else if (wrap)                          ref_pend <= 1'b1;
    else if (st == S_ARBIT && ref_pend)     ref_pend <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sdram_cke <= 1'b0;
    else        sdram_cke <= 1'b1;
  end

  // Grants are levels: an *_en stays high from the grant cycle until the owning
  // sequencer's end pulse is sampled; every grant is separated by one ARBIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= S_INIT;
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
    end else begin
      case (st)
        S_INIT: begin
          if (flag_init_end) st <= S_ARBIT;
        end
        S_ARBIT: begin
          if (ref_pend) begin
            st     <= S_AREF;
            ref_en <= 1'b1;
          end else if (wr_req) begin
            st    <= S_WRITE;
            wr_en <= 1'b1;
          end else if (rd_req) begin
            st    <= S_READ;
            rd_en <= 1'b1;
          end
        end
        S_AREF: begin
          if (flag_ref_end) begin
            st     <= S_ARBIT;
            ref_en <= 1'b0;
          end
        end
        S_WRITE: begin
          if (wr_end) begin
            st    <= S_ARBIT;
            wr_en <= 1'b0;
          end
        end
        S_READ: begin
          if (rd_end) begin
            st    <= S_ARBIT;
            rd_en <= 1'b0;
          end
        end
        default: begin
          st     <= S_INIT;
          ref_en <= 1'b0;
          wr_en  <= 1'b0;
          rd_en  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    case (st)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: per-cycle expected outputs are queued by the
// driver and compared by an independent monitor after each rising edge.
module tb_sdram_arbit;

  localparam int W = 27;
  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_ARBIT = 3'd1;
  localparam logic [2:0] S_AREF  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  localparam logic [3:0]  INIT_CMD  = 4'b0001;
  localparam logic [12:0] INIT_ADDR = 13'h0400;
  localparam logic [3:0]  REF_CMD   = 4'b0010;
  localparam logic [12:0] REF_ADDR  = 13'h0123;
  localparam logic [3:0]  WR_CMD    = 4'b0100;
  localparam logic [12:0] WR_ADDR   = 13'h0aaa;
  localparam logic [1:0]  WR_BANK   = 2'b10;
  localparam logic [3:0]  RD_CMD    = 4'b0101;
  localparam logic [12:0] RD_ADDR   = 13'h1555;
  localparam logic [1:0]  RD_BANK   = 2'b01;

  logic        clk, rst_n, flag_init_end, flag_ref_end;
  logic        wr_req, rd_req, wr_end, rd_end;
  logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
  logic [12:0] init_addr, ref_addr, wr_addr, rd_addr;
  logic [1:0]  wr_bank, rd_bank;
  logic        ref_en, wr_en, rd_en, ref_pend, sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [2:0]  state;

  sdram_arbit dut (
    .clk(clk), .rst_n(rst_n), .flag_init_end(flag_init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_cmd(ref_cmd), .ref_addr(ref_addr), .flag_ref_end(flag_ref_end),
    .wr_req(wr_req), .rd_req(rd_req),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .wr_end(wr_end), .rd_end(rd_end),
    .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .ref_pend(ref_pend),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_bank(sdram_bank), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  string phase = "start";

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] act, e;
  string        n;

  assign act = {state, ref_en, wr_en, rd_en, ref_pend, sdram_cke,
                sdram_cmd, sdram_bank, sdram_addr};

  function automatic logic [W-1:0] ex(input logic [2:0] s, input logic pend,
                                      input logic cke_e);
    logic r, w, rd;
    logic [3:0] c;
    logic [1:0] b;
    logic [12:0] a;
    r = 1'b0; w = 1'b0; rd = 1'b0;
    c = 4'b0111; b = 2'b00; a = 13'h0;
    case (s)
      S_INIT:  begin c = INIT_CMD; a = INIT_ADDR; end
      S_AREF:  begin c = REF_CMD;  a = REF_ADDR; r = 1'b1; end
      S_WRITE: begin c = WR_CMD;   a = WR_ADDR; b = WR_BANK; w = 1'b1; end
      S_READ:  begin c = RD_CMD;   a = RD_ADDR; b = RD_BANK; rd = 1'b1; end
      default: ;
    endcase
    return {s, r, w, rd, pend, cke_e, c, b, a};
  endfunction

  // driver tasks
  task automatic step(input logic [2:0] s, input logic pend, input logic cke_e);
    exp_q.push_back(ex(s, pend, cke_e));
    name_q.push_back(phase);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s @cyc%0d: got %h expected %h", n, cyc, act, e);
      end
    end
    tests++;
    if ($countones({ref_en, wr_en, rd_en}) > 1) begin
      fails++;
      $display("FAIL onehot_grant: got %b expected at most one set", {ref_en, wr_en, rd_en});
    end
    if (ref_en || wr_en || rd_en) begin
      tests++;
      if (sdram_cmd !== (ref_en ? REF_CMD : wr_en ? WR_CMD : RD_CMD)) begin
        fails++;
        $display("FAIL grant_cmd: got %b expected %b", sdram_cmd,
                 ref_en ? REF_CMD : wr_en ? WR_CMD : RD_CMD);
      end
    end
  end

  initial begin
    init_cmd = INIT_CMD; init_addr = INIT_ADDR;
    ref_cmd = REF_CMD; ref_addr = REF_ADDR;
    wr_cmd = WR_CMD; wr_addr = WR_ADDR; wr_bank = WR_BANK;
    rd_cmd = RD_CMD; rd_addr = RD_ADDR; rd_bank = RD_BANK;
    rst_n = 1'b0; flag_init_end = 1'b0; flag_ref_end = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_end = 1'b0; rd_end = 1'b0;

    phase = "reset";
    repeat (3) step(S_INIT, 1'b0, 1'b0);
    rst_n = 1'b1;
    phase = "init_hold";
    repeat (100) step(S_INIT, 1'b0, 1'b1);

    phase = "init_done";
    flag_init_end = 1'b1;
    cyc = 0;
    step(S_ARBIT, 1'b0, 1'b1);
    phase = "timer";
    while (cyc < 389) step(S_ARBIT, 1'b0, 1'b1);
    step(S_ARBIT, 1'b1, 1'b1);
    phase = "aref_first";
    step(S_AREF, 1'b0, 1'b1);
    wr_req = 1'b1;
    repeat (3) step(S_AREF, 1'b0, 1'b1);
    flag_ref_end = 1'b1;
    step(S_ARBIT, 1'b0, 1'b1);
    flag_ref_end = 1'b0;
    rd_req = 1'b1;

    phase = "wr_over_rd";
    repeat (4) step(S_WRITE, 1'b0, 1'b1);
    wr_end = 1'b1; wr_req = 1'b0;
    step(S_ARBIT, 1'b0, 1'b1);
    wr_end = 1'b0;
    phase = "rd_after_wr";
    repeat (3) step(S_READ, 1'b0, 1'b1);
    rd_end = 1'b1; rd_req = 1'b0;
    step(S_ARBIT, 1'b0, 1'b1);
    rd_end = 1'b0;

    phase = "idle";
    while (cyc < 770) step(S_ARBIT, 1'b0, 1'b1);
    phase = "ref_in_write";
    wr_req = 1'b1;
    while (cyc < 779) step(S_WRITE, 1'b0, 1'b1);
    while (cyc < 784) step(S_WRITE, 1'b1, 1'b1);
    wr_end = 1'b1;
    step(S_ARBIT, 1'b1, 1'b1);
    wr_end = 1'b0;
    repeat (3) step(S_AREF, 1'b0, 1'b1);
    flag_ref_end = 1'b1;
    step(S_ARBIT, 1'b0, 1'b1);
    flag_ref_end = 1'b0;
    step(S_WRITE, 1'b0, 1'b1);
    wr_end = 1'b1; wr_req = 1'b0;
    step(S_ARBIT, 1'b0, 1'b1);
    wr_end = 1'b0;

    phase = "long_read";
    rd_req = 1'b1;
    while (cyc < 1600) step(S_READ, cyc >= 1169, 1'b1);
    rd_end = 1'b1; rd_req = 1'b0;
    step(S_ARBIT, 1'b1, 1'b1);
    rd_end = 1'b0;
    step(S_AREF, 1'b0, 1'b1);
    flag_ref_end = 1'b1;
    step(S_ARBIT, 1'b0, 1'b1);
    flag_ref_end = 1'b0;
    phase = "single_aref";
    while (cyc < 1611) step(S_ARBIT, 1'b0, 1'b1);

    phase = "reset_mid";
    wr_req = 1'b1;
    repeat (2) step(S_WRITE, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0; flag_init_end = 1'b0;
    #1;
    chk("async_wr_en", {31'd0, wr_en}, 32'd0);
    chk("async_cke", {31'd0, sdram_cke}, 32'd0);
    chk("async_state", {29'd0, state}, {29'd0, S_INIT});
    chk("async_cmd", {28'd0, sdram_cmd}, {28'd0, INIT_CMD});
    step(S_INIT, 1'b0, 1'b0);
    rst_n = 1'b1;
    rd_req = 1'b1;
    phase = "no_grant";
    repeat (10) step(S_INIT, 1'b0, 1'b1);
    phase = "reinit";
    flag_init_end = 1'b1;
    step(S_ARBIT, 1'b0, 1'b1);
    step(S_WRITE, 1'b0, 1'b1);
    wr_end = 1'b1; wr_req = 1'b0;
    step(S_ARBIT, 1'b0, 1'b1);
    wr_end = 1'b0;
    step(S_READ, 1'b0, 1'b1);
    rd_end = 1'b1; rd_req = 1'b0;
    step(S_ARBIT, 1'b0, 1'b1);
    rd_end = 1'b0;
    step(S_ARBIT, 1'b0, 1'b1);

    // final report
    @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
